m_stage_pipe_reg: RTL and testbench
===================================

// Module: m_stage_pipe_reg
// PURPOSE
//   Parametrised E->M pipeline register for the 5-stage MIPS core.
//   - Generic payload lanes, replacing fixed per-signal regs.
//   - Stall/flush control and a data-memory wait handshake.
//   - Tnew carried from E and decremented on capture, so M no longer decodes it.
//   - Raises m_busy to freeze upstream stages while a memory access is outstanding.
// PARAMETERS
//   DATA_W    32            width of one payload lane
//   LANES     5             payload lanes (rs data, rt data, alu, ext, muldiv)
//   TNEW_W    3             Tnew field width
//   RESET_PC  32'h0000_3000 m_pc value after reset
// PORTS
//   clk          in   1               clock, rising edge
//   reset        in   1               asynchronous, active-low reset
//   e_valid      in   1               E slot holds a real instruction
//   e_instr      in   32              instruction in E
//   e_pc         in   32              PC in E
//   e_payload    in   LANES*DATA_W    lane k = bits [k*DATA_W +: DATA_W]
//   e_tnew       in   TNEW_W          Tnew of the instruction in E
//   e_is_mem     in   1               instruction is a load or store
//   stall_i      in   1               hazard unit holds M
//   flush_i      in   1               insert bubble into M
//   mem_ack_i    in   1               data memory completes request
//   mem_req_o    out  1               data memory request
//   m_busy       out  1               M waiting on memory; upstream must freeze
//   m_valid      out  1               M holds a real instruction
//   m_instr      out  32              instruction in M (NOP = 32'h0 when bubble)
//   m_pc         out  32              PC in M
//   m_payload    out  LANES*DATA_W    registered lanes
//   m_tnew       out  TNEW_W          Tnew in M
// BEHAVIOUR
//   - Reset (reset=0, async) sets:
//     - m_valid=0, m_instr=0, m_pc=RESET_PC, m_payload=0, m_tnew=0.
//     - state=RUN, mem_req_o=0, flush_pend=0.
//   - cap = !stall_i && !m_busy. m_busy = (state==MEM_WAIT) && !mem_ack_i (combinational).
//   - State RUN; on cap:
//     - flush_i: load bubble (valid 0, instr 0, payload 0, tnew 0).
//     - else: load E fields; m_tnew = (e_tnew==0) ? 0 : e_tnew-1.
//     - Captured e_valid && e_is_mem && !flush_i -> MEM_WAIT.
//   - State RUN without cap: all M fields hold; flush_i does not flush. The hazard
//     unit never asserts flush_i together with stall_i.
//   - State MEM_WAIT:
//     - mem_req_o=1 and fields hold.
//     - On mem_ack_i -> RUN; M captures the next E on that same edge if !stall_i.
//     - mem_ack_i in the first MEM_WAIT cycle gives a 1-cycle access; there is no minimum.
//   - flush_i while in MEM_WAIT:
//     - The in-flight access is never abandoned; set flush_pend.
//     - The capture on the ack edge loads a bubble and clears flush_pend.
//   - mem_req_o in RUN is 0. mem_ack_i seen in RUN is ignored.
//   - Reset mid-MEM_WAIT: drop to RUN immediately; mem_req_o falls asynchronously.
//   - Latency E->M = 1 cycle; M occupancy = 1 + wait cycles.
// CONFIGURATION
//   M_STAGE_EXC_EN
//   - Defined:
//     - Adds ports e_exc[4:0], e_bd, m_exc[4:0], m_bd, registered like payload.
//     - Captured e_exc!=0 suppresses the access: stay RUN, mem_req_o=0.
//     - m_exc/m_bd reset to 0; bubble sets both to 0.
//   - Undefined: ports absent; every valid e_is_mem capture enters MEM_WAIT.
// TESTING
//   1. Reset sequence:
//      - reset=0 then 1 -> m_instr=0, m_pc=32'h3000, m_valid=0, mem_req_o=0.
//   2. Plain ALU op:
//      - Capture e_instr=addu, e_tnew=1 -> next cycle m_valid=1, m_tnew=0.
//      - e_tnew=0 -> m_tnew=0 (saturates).
//   3. Load with 3-cycle wait:
//      - Capture lw, ack on 3rd MEM_WAIT cycle -> mem_req_o high 3 cycles, m_busy high 2.
//      - M holds through the wait, then takes the next E.
//   4. Flush during MEM_WAIT:
//      - flush_i pulse in cycle 1 of wait, ack in cycle 2 -> M becomes a bubble (m_instr=0).
//   5. Stall in RUN:
//      - stall_i=1 for 4 cycles with changing E -> m_* unchanged.
//      - Release -> loads current E.
//   6. M_STAGE_EXC_EN:
//      - Capture sw with e_exc=5'd5 -> mem_req_o never rises; m_exc=5.

Source files
------------

// File: rtl/m_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// m_stage_pipe_reg
//   E->M pipeline register for the 5-stage MIPS core.
//   - Carries a generic set of payload lanes (rs data, rt data, alu, ext,
//     muldiv) instead of one register per signal.
//   - Tnew arrives from E and is decremented (saturating at 0) on capture, so
//     the M stage never has to decode it.
//   - A load/store captured into M raises mem_req_o and sits in MEM_WAIT until
//     the data memory acks. While the ack is outstanding m_busy freezes the
//     upstream stages.
//
// Configuration macro:
//   M_STAGE_EXC_EN  adds exception/branch-delay tracking (e_exc, e_bd,
//                   m_exc, m_bd). A captured instruction with a non-zero
//                   exception code does not start a memory access.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   e_valid    E slot holds a real instruction
//   e_instr    instruction in E
//   e_pc       PC in E
//   e_payload  LANES lanes, lane k = bits [k*DATA_W +: DATA_W]
//   e_tnew     Tnew of the instruction in E
//   e_is_mem   instruction in E is a load or store
//   stall_i    hazard unit holds M
//   flush_i    insert a bubble into M
//   mem_ack_i  data memory completes the outstanding request
//   mem_req_o  data memory request (high for the whole MEM_WAIT period)
//   m_busy     M is waiting on memory; upstream must freeze
//   m_valid    M holds a real instruction
//   m_instr    instruction in M (32'h0 for a bubble)
//   m_pc       PC in M
//   m_payload  registered payload lanes
//   m_tnew     Tnew in M
// ---------------------------------------------------------------------------
module m_stage_pipe_reg #(
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned LANES    = 5,
   parameter int unsigned TNEW_W   = 3,
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    e_valid,
   input  logic [31:0]             e_instr,
   input  logic [31:0]             e_pc,
   input  logic [LANES*DATA_W-1:0] e_payload,
   input  logic [TNEW_W-1:0]       e_tnew,
   input  logic                    e_is_mem,
`ifdef M_STAGE_EXC_EN
   input  logic [4:0]              e_exc,
   input  logic                    e_bd,
`endif
   input  logic                    stall_i,
   input  logic                    flush_i,
   input  logic                    mem_ack_i,
   output logic                    mem_req_o,
   output logic                    m_busy,
   output logic                    m_valid,
   output logic [31:0]             m_instr,
   output logic [31:0]             m_pc,
   output logic [LANES*DATA_W-1:0] m_payload,
`ifdef M_STAGE_EXC_EN
   output logic [4:0]              m_exc,
   output logic                    m_bd,
`endif
   output logic [TNEW_W-1:0]       m_tnew
);

   localparam logic [0:0] ST_RUN      = 1'b0;
   localparam logic [0:0] ST_MEM_WAIT = 1'b1;

   logic [0:0]        state;
   logic [0:0]        state_nxt;
   logic              flush_pend;
   logic              flush_pend_nxt;
   logic              cap;
   logic              bubble;
   logic              enter_mem;
   logic [TNEW_W-1:0] tnew_dec;

   // ------------------------------------------------------------------------
   // Handshake outputs. mem_req_o is decoded from the state register, so an
   // asynchronous reset in MEM_WAIT drops it immediately.
   // ------------------------------------------------------------------------
   assign mem_req_o = (state == ST_MEM_WAIT);
   assign m_busy    = (state == ST_MEM_WAIT) && !mem_ack_i;
   assign cap       = !stall_i && !m_busy;

   // A flush seen while waiting on memory is remembered and applied at the
   // first capture after the ack, so the access itself is never abandoned.
   assign bubble    = flush_i || flush_pend;

   assign tnew_dec  = (e_tnew == '0) ? '0 : e_tnew - TNEW_W'(1);

`ifdef M_STAGE_EXC_EN
   // An excepting instruction must not touch data memory.
   assign enter_mem = e_valid && e_is_mem && !bubble && (e_exc == '0);
`else
   assign enter_mem = e_valid && e_is_mem && !bubble;
`endif

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      flush_pend_nxt = flush_pend;
      if (cap) begin
         // Covers both the RUN capture and the capture on the ack edge.
         state_nxt      = enter_mem ? ST_MEM_WAIT : ST_RUN;
         flush_pend_nxt = 1'b0;
      end else if (state == ST_MEM_WAIT) begin
         if (mem_ack_i) begin
            // Ack while stalled: leave MEM_WAIT, M holds until released.
            state_nxt = ST_RUN;
         end
         if (flush_i) begin
            flush_pend_nxt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_RUN;
         flush_pend <= 1'b0;
      end else begin
         state      <= state_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // M-stage fields
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_valid   <= 1'b0;
         m_instr   <= '0;
         m_pc      <= RESET_PC;
         m_payload <= '0;
         m_tnew    <= '0;
      end else if (cap) begin
         m_pc <= e_pc;
         if (bubble) begin
            m_valid   <= 1'b0;
            m_instr   <= '0;
            m_payload <= '0;
            m_tnew    <= '0;
         end else begin
            m_valid   <= e_valid;
            m_instr   <= e_instr;
            m_payload <= e_payload;
            m_tnew    <= tnew_dec;
         end
      end
   end

`ifdef M_STAGE_EXC_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_exc <= '0;
         m_bd  <= 1'b0;
      end else if (cap) begin
         if (bubble) begin
            m_exc <= '0;
            m_bd  <= 1'b0;
         end else begin
            m_exc <= e_exc;
            m_bd  <= e_bd;
         end
      end
   end
`endif

endmodule

// File: tb/tb_m_stage_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_m_stage_pipe_reg
//   Directed bench for m_stage_pipe_reg. The driver applies one input vector
//   per cycle (just after the rising edge) and pushes the hand-computed
//   outputs expected mid-cycle; the monitor pops and compares on each falling
//   edge. Define M_STAGE_EXC_EN to include the exception-suppression case.
// ---------------------------------------------------------------------------
module tb_m_stage_pipe_reg;

   localparam int unsigned DW = 32;
   localparam int unsigned LN = 5;
   localparam int unsigned TW = 3;
   localparam int unsigned PW = LN * DW;

   logic          clk;
   logic          reset;
   logic          e_valid;
   logic [31:0]   e_instr;
   logic [31:0]   e_pc;
   logic [PW-1:0] e_payload;
   logic [TW-1:0] e_tnew;
   logic          e_is_mem;
   logic          stall_i;
   logic          flush_i;
   logic          mem_ack_i;
   logic          mem_req_o;
   logic          m_busy;
   logic          m_valid;
   logic [31:0]   m_instr;
   logic [31:0]   m_pc;
   logic [PW-1:0] m_payload;
   logic [TW-1:0] m_tnew;
`ifdef M_STAGE_EXC_EN
   logic [4:0]    e_exc;
   logic          e_bd;
   logic [4:0]    m_exc;
   logic          m_bd;
`endif

   m_stage_pipe_reg #(
      .DATA_W  (DW),
      .LANES   (LN),
      .TNEW_W  (TW),
      .RESET_PC(32'h0000_3000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .e_valid  (e_valid),
      .e_instr  (e_instr),
      .e_pc     (e_pc),
      .e_payload(e_payload),
      .e_tnew   (e_tnew),
      .e_is_mem (e_is_mem),
`ifdef M_STAGE_EXC_EN
      .e_exc    (e_exc),
      .e_bd     (e_bd),
      .m_exc    (m_exc),
      .m_bd     (m_bd),
`endif
      .stall_i  (stall_i),
      .flush_i  (flush_i),
      .mem_ack_i(mem_ack_i),
      .mem_req_o(mem_req_o),
      .m_busy   (m_busy),
      .m_valid  (m_valid),
      .m_instr  (m_instr),
      .m_pc     (m_pc),
      .m_payload(m_payload),
      .m_tnew   (m_tnew)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string         name;
      logic          v;
      logic [31:0]   instr;
      logic [31:0]   pc;
      logic [TW-1:0] tnew;
      logic [PW-1:0] pay;
      logic          req;
      logic          busy;
      logic          chk_pc;
      logic [4:0]    exc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   localparam logic [31:0] ADDU1 = 32'h0043_0821;
   localparam logic [31:0] ADDU2 = 32'h0085_1021;
   localparam logic [31:0] ADDU3 = 32'h00a6_1821;
   localparam logic [31:0] LW    = 32'h8c22_0004;
   localparam logic [31:0] SW    = 32'hac22_0008;

   function automatic logic [PW-1:0] pay(input logic [31:0] pc);
      logic [PW-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < LN; k++) r[k*DW +: DW] = pc + k;
      return r;
   endfunction

   task automatic chk(input string nm, input string fld,
                      input logic [PW-1:0] act, input logic [PW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
      end
   endtask

   // Monitor: one expectation per cycle, sampled mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.name, "m_valid",   PW'(m_valid),   PW'(e.v));
            chk(e.name, "m_instr",   PW'(m_instr),   PW'(e.instr));
            if (e.chk_pc) chk(e.name, "m_pc", PW'(m_pc), PW'(e.pc));
            chk(e.name, "m_tnew",    PW'(m_tnew),    PW'(e.tnew));
            chk(e.name, "m_payload", m_payload,      e.pay);
            chk(e.name, "mem_req_o", PW'(mem_req_o), PW'(e.req));
            chk(e.name, "m_busy",    PW'(m_busy),    PW'(e.busy));
`ifdef M_STAGE_EXC_EN
            chk(e.name, "m_exc",     PW'(m_exc),     PW'(e.exc));
`endif
         end
      end
   end

   task automatic drive_e(input logic v, input logic [31:0] instr,
                          input logic [31:0] pc, input logic [TW-1:0] tnew,
                          input logic is_mem);
      e_valid   = v;
      e_instr   = instr;
      e_pc      = pc;
      e_tnew    = tnew;
      e_is_mem  = is_mem;
      e_payload = pay(pc);
   endtask

   task automatic expect_m(input string nm, input logic v,
                           input logic [31:0] instr, input logic [31:0] pc,
                           input logic [TW-1:0] tnew, input logic [PW-1:0] p,
                           input logic req, input logic busy,
                           input logic chk_pc, input logic [4:0] exc);
      exp_t e;
      e.name = nm; e.v = v; e.instr = instr; e.pc = pc; e.tnew = tnew;
      e.pay = p; e.req = req; e.busy = busy; e.chk_pc = chk_pc; e.exc = exc;
      q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic ctl(input logic rst, input logic st, input logic fl,
                      input logic ack);
      reset     = rst;
      stall_i   = st;
      flush_i   = fl;
      mem_ack_i = ack;
   endtask

   initial begin
`ifdef M_STAGE_EXC_EN
      e_exc = '0;
      e_bd  = 1'b0;
`endif
      ctl(1'b0, 1'b0, 1'b0, 1'b0);
      drive_e(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      next_cycle();

      // c0: in reset
      expect_m("rst_hold", 0, 32'h0, 32'h3000, 0, '0, 0, 0, 1, 0);
      next_cycle();
      // c1: release reset, present addu (tnew 1)
      ctl(1'b1, 1'b0, 1'b0, 1'b0);
      drive_e(1'b1, ADDU1, 32'h3000, 3'd1, 1'b0);
      expect_m("rst_release", 0, 32'h0, 32'h3000, 0, '0, 0, 0, 1, 0);
      next_cycle();
      // c2: addu in M, tnew 1 -> 0; present addu with tnew 0
      drive_e(1'b1, ADDU2, 32'h3004, 3'd0, 1'b0);
      expect_m("alu_tnew1", 1, ADDU1, 32'h3000, 0, pay(32'h3000), 0, 0, 1, 0);
      next_cycle();
      // c3: tnew saturates at 0; present lw
      drive_e(1'b1, LW, 32'h3008, 3'd2, 1'b0 | 1'b1);
      expect_m("alu_tnew0", 1, ADDU2, 32'h3004, 0, pay(32'h3004), 0, 0, 1, 0);
      next_cycle();
      // c4..c6: lw waits, ack in third wait cycle; addu3 held in E
      drive_e(1'b1, ADDU3, 32'h300c, 3'd2, 1'b0);
      expect_m("lw_wait1", 1, LW, 32'h3008, 1, pay(32'h3008), 1, 1, 1, 0);
      next_cycle();
      expect_m("lw_wait2", 1, LW, 32'h3008, 1, pay(32'h3008), 1, 1, 1, 0);
      next_cycle();
      ctl(1'b1, 1'b0, 1'b0, 1'b1);
      expect_m("lw_ack", 1, LW, 32'h3008, 1, pay(32'h3008), 1, 0, 1, 0);
      next_cycle();
      // c7..c10: stall with changing E
      ctl(1'b1, 1'b1, 1'b0, 1'b0);
      drive_e(1'b1, 32'h0001_0001, 32'h3010, 3'd1, 1'b0);
      expect_m("after_lw", 1, ADDU3, 32'h300c, 1, pay(32'h300c), 0, 0, 1, 0);
      next_cycle();
      drive_e(1'b1, 32'h0002_0002, 32'h3014, 3'd2, 1'b1);
      expect_m("stall1", 1, ADDU3, 32'h300c, 1, pay(32'h300c), 0, 0, 1, 0);
      next_cycle();
      drive_e(1'b0, 32'h0003_0003, 32'h3018, 3'd3, 1'b0);
      expect_m("stall2", 1, ADDU3, 32'h300c, 1, pay(32'h300c), 0, 0, 1, 0);
      next_cycle();
      drive_e(1'b1, 32'h0004_0004, 32'h301c, 3'd1, 1'b0);
      expect_m("stall3", 1, ADDU3, 32'h300c, 1, pay(32'h300c), 0, 0, 1, 0);
      next_cycle();
      // c11: release, present sw
      ctl(1'b1, 1'b0, 1'b0, 1'b0);
      drive_e(1'b1, SW, 32'h3020, 3'd0, 1'b1);
      expect_m("stall4", 1, ADDU3, 32'h300c, 1, pay(32'h300c), 0, 0, 1, 0);
      next_cycle();
      // c12: sw waiting, flush pulse in first wait cycle
      ctl(1'b1, 1'b0, 1'b1, 1'b0);
      drive_e(1'b1, ADDU1, 32'h3024, 3'd1, 1'b0);
      expect_m("sw_wait1", 1, SW, 32'h3020, 0, pay(32'h3020), 1, 1, 1, 0);
      next_cycle();
      // c13: ack in second wait cycle
      ctl(1'b1, 1'b0, 1'b0, 1'b1);
      expect_m("sw_ack", 1, SW, 32'h3020, 0, pay(32'h3020), 1, 0, 1, 0);
      next_cycle();
      // c14: bubble in M; ack in RUN must be ignored; present lw
      drive_e(1'b1, LW, 32'h3028, 3'd2, 1'b1);
      expect_m("flush_bubble", 0, 32'h0, 32'h0, 0, '0, 0, 0, 0, 0);
      next_cycle();
      // c15: lw in M, single-cycle access
      drive_e(1'b0, 32'h0, 32'h302c, 3'd0, 1'b0);
      expect_m("lw_1cyc", 1, LW, 32'h3028, 1, pay(32'h3028), 1, 0, 1, 0);
      next_cycle();
      // c16: invalid E captured as-is; present another lw
      ctl(1'b1, 1'b0, 1'b0, 1'b0);
      drive_e(1'b1, LW, 32'h3030, 3'd2, 1'b1);
      expect_m("idle_cap", 0, 32'h0, 32'h302c, 0, pay(32'h302c), 0, 0, 1, 0);
      next_cycle();
      // c17: lw waiting; reset asserted mid-cycle, request drops without a clock
      drive_e(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      expect_m("rst_midwait", 0, 32'h0, 32'h3000, 0, '0, 0, 0, 1, 0);
      #2 reset = 1'b0;
      next_cycle();
      // c18: release reset
      reset = 1'b1;
`ifdef M_STAGE_EXC_EN
      drive_e(1'b1, SW, 32'h3040, 3'd1, 1'b1);
      e_exc = 5'd5;
`endif
      expect_m("rst_again", 0, 32'h0, 32'h3000, 0, '0, 0, 0, 1, 0);
      next_cycle();
`ifdef M_STAGE_EXC_EN
      // c19: excepting sw in M, no memory request
      drive_e(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
      e_exc = 5'd0;
      expect_m("exc_sw", 1, SW, 32'h3040, 0, pay(32'h3040), 0, 0, 1, 5'd5);
      next_cycle();
      expect_m("exc_after", 0, 32'h0, 32'h0, 0, pay(32'h0), 0, 0, 1, 5'd0);
      next_cycle();
`endif
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
